// File: rtl/button_controller.sv
// button_controller: synchronizes and debounces four buttons and latches
// press/release/vblank-start events, answering ulisp register-bus reads.
module button_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BASE_INDEX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  buttons_i,
  input  logic        in_vblank_i,
  input  logic [6:0]  register_index_i,
  input  logic        register_read_i,
  output logic [15:0] register_read_value_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] sync0, sync1, state, press_lat, release_lat, accept, press_evt, release_evt;
  logic [CW-1:0] cnt [4];
  logic prev_vblank, vbs_lat, vbs_evt, hit;
  logic [7:0] off;
  logic [15:0] rdata;
  always_comb begin
    for (int i = 0; i < 4; i++) accept[i] = sync1[i] != state[i] && cnt[i] == LAST;
  end
  assign press_evt = accept & sync1;
  assign release_evt = accept & ~sync1;
  assign vbs_evt = in_vblank_i & ~prev_vblank;
  // indices below BASE_INDEX wrap to large offsets and miss the decode
  assign off = {1'b0, register_index_i} - 8'(BASE_INDEX);
  assign hit = register_read_i && off < 8'd4;
  always_comb
    rdata = off[1:0] == 2'd0 ? {12'd0, state} :
            off[1:0] == 2'd1 ? {12'd0, press_lat | press_evt} :
            off[1:0] == 2'd2 ? {12'd0, release_lat | release_evt} :
                               {14'd0, vbs_lat | vbs_evt, in_vblank_i};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
      state <= '0;
      press_lat <= '0;
      release_lat <= '0;
      vbs_lat <= 1'b0;
      prev_vblank <= 1'b0;
      register_read_value_o <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync0 <= buttons_i;
      sync1 <= sync0;
      state <= state ^ accept;
      prev_vblank <= in_vblank_i;
      press_lat <= hit && off[1:0] == 2'd1 ? 4'd0 : press_lat | press_evt;
      release_lat <= hit && off[1:0] == 2'd2 ? 4'd0 : release_lat | release_evt;
      vbs_lat <= hit && off[1:0] == 2'd3 ? 1'b0 : vbs_lat | vbs_evt;
      if (hit) register_read_value_o <= rdata;
      for (int i = 0; i < 4; i++) cnt[i] <= sync1[i] == state[i] || accept[i] ? '0 : cnt[i] + 1'b1;
    end
endmodule

// File: tb/tb_button_controller.sv
// tb_button_controller: directed scenarios plus randomized traffic checked
// against a window-based behavioural model of debounce and event latching.
module tb_button_controller;
  localparam int D = 4;
  logic clk = 0, reset = 1, vbl = 0, rd = 0;
  logic [3:0] buttons = 0;
  logic [6:0] idx = 0;
  logic [15:0] rv;
  int nvec = 0, nfail = 0;

  button_controller #(.DEBOUNCE_CYCLES(D), .BASE_INDEX(8)) dut (
    .clk(clk), .reset(reset), .buttons_i(buttons), .in_vblank_i(vbl),
    .register_index_i(idx), .register_read_i(rd), .register_read_value_o(rv)
  );

  always #5 clk = ~clk;

  // model: a button is accepted once its synchronized value has disagreed
  // with the debounced state for the last D cycles in a row
  logic [3:0] m_s0, m_s1, m_state, m_press, m_rel;
  logic m_prev, m_vbs;
  logic [15:0] m_out;
  logic [3:0] hist[$];

  task automatic m_clear();
    m_s0 = 0; m_s1 = 0; m_state = 0; m_press = 0; m_rel = 0;
    m_prev = 0; m_vbs = 0; m_out = 0;
    hist.delete();
  endtask

  task automatic m_edge();
    logic [3:0] acc, pe, re;
    logic ve, all_diff, hit;
    int o;
    acc = 0;
    hist.push_back(m_s1);
    if (hist.size() > D) void'(hist.pop_front());
    if (hist.size() == D)
      for (int i = 0; i < 4; i++) begin
        all_diff = 1;
        foreach (hist[k]) if (hist[k][i] == m_state[i]) all_diff = 0;
        acc[i] = all_diff;
      end
    pe = acc & m_s1;
    re = acc & ~m_s1;
    ve = vbl & ~m_prev;
    o = int'(idx) - 8;
    hit = rd && o >= 0 && o <= 3;
    if (hit)
      m_out = o == 0 ? {12'd0, m_state} : o == 1 ? {12'd0, m_press | pe} :
              o == 2 ? {12'd0, m_rel | re} : {14'd0, m_vbs | ve, vbl};
    m_press = (hit && o == 1) ? 4'd0 : m_press | pe;
    m_rel = (hit && o == 2) ? 4'd0 : m_rel | re;
    m_vbs = (hit && o == 3) ? 1'b0 : m_vbs | ve;
    m_state = m_state ^ acc;
    m_prev = vbl;
    m_s1 = m_s0;
    m_s0 = buttons;
  endtask

  task automatic cycle(input logic [3:0] b, input logic v, input logic r, input logic [6:0] i);
    buttons = b; vbl = v; rd = r; idx = i;
    if (!reset) m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_clear();
    repeat (2) cycle(0, 0, 0, 0);
    reset = 0;
    repeat (D + 3) cycle(4'hF, 0, 0, 0);
    cycle(4'hF, 0, 1, 8);
    nvec++; if (rv !== 16'h000F) begin nfail++; $display("FAIL pre_reset_state got %h want %h", rv, 16'h000F); end
    #3 reset = 1;
    m_clear();
    #1;
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL async_reset_out got %h want %h", rv, 16'h0000); end
    repeat (2) cycle(4'hF, 0, 1, 9);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL held_reset_out got %h want %h", rv, 16'h0000); end
    reset = 0;
    repeat (2 + D) cycle(4'hF, 0, 0, 0);
    cycle(4'hF, 0, 1, 8);
    nvec++; if (rv !== 16'h000F) begin nfail++; $display("FAIL reset_held_state got %h want %h", rv, 16'h000F); end
    cycle(4'hF, 0, 1, 9);
    nvec++; if (rv !== 16'h000F) begin nfail++; $display("FAIL reset_held_press got %h want %h", rv, 16'h000F); end
  endtask

  task automatic test_debounce();
    repeat (D + 3) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 9); cycle(0, 0, 1, 10); cycle(0, 0, 1, 11);
    repeat (3) cycle(4'h2, 0, 0, 0);
    repeat (D + 3) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 8);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL glitch_state got %h want %h", rv, 16'h0000); end
    cycle(0, 0, 1, 9);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL glitch_press got %h want %h", rv, 16'h0000); end
    repeat (5) cycle(4'h2, 0, 0, 0);
    cycle(4'h2, 0, 1, 8);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL accept_not_early got %h want %h", rv, 16'h0000); end
    cycle(4'h2, 0, 1, 8);
    nvec++; if (rv !== 16'h0002) begin nfail++; $display("FAIL accept_edge got %h want %h", rv, 16'h0002); end
    cycle(4'h2, 0, 1, 9);
    nvec++; if (rv !== 16'h0002) begin nfail++; $display("FAIL accept_press got %h want %h", rv, 16'h0002); end
  endtask

  task automatic test_clear_on_read();
    repeat (D + 3) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 9); cycle(0, 0, 1, 10);
    repeat (D + 3) cycle(4'h4, 0, 0, 0);
    repeat (D + 3) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 10);
    nvec++; if (rv !== 16'h0004) begin nfail++; $display("FAIL release_first got %h want %h", rv, 16'h0004); end
    cycle(0, 0, 1, 10);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL release_second got %h want %h", rv, 16'h0000); end
    cycle(0, 0, 1, 8);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL release_state got %h want %h", rv, 16'h0000); end
  endtask

  task automatic test_simultaneous();
    cycle(0, 0, 1, 9);
    repeat (5) cycle(4'h1, 0, 0, 0);
    cycle(4'h1, 0, 1, 9);
    nvec++; if (rv !== 16'h0001) begin nfail++; $display("FAIL simul_read got %h want %h", rv, 16'h0001); end
    cycle(4'h1, 0, 1, 9);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL simul_reread got %h want %h", rv, 16'h0000); end
  endtask

  task automatic test_vblank();
    cycle(4'h1, 0, 0, 0);
    repeat (2) cycle(4'h1, 1, 0, 0);
    cycle(4'h1, 1, 1, 11);
    nvec++; if (rv !== 16'h0003) begin nfail++; $display("FAIL vblank_first got %h want %h", rv, 16'h0003); end
    cycle(4'h1, 1, 1, 11);
    nvec++; if (rv !== 16'h0001) begin nfail++; $display("FAIL vblank_second got %h want %h", rv, 16'h0001); end
    repeat (6) cycle(4'h1, 1, 0, 0);
    cycle(4'h1, 0, 0, 0);
    cycle(4'h1, 0, 1, 11);
    nvec++; if (rv !== 16'h0000) begin nfail++; $display("FAIL vblank_after got %h want %h", rv, 16'h0000); end
  endtask

  task automatic test_decode();
    cycle(4'h1, 0, 1, 8);
    nvec++; if (rv !== 16'h0001) begin nfail++; $display("FAIL decode_base got %h want %h", rv, 16'h0001); end
    repeat (D + 3) cycle(4'h3, 0, 0, 0);
    cycle(4'h3, 0, 1, 7);
    nvec++; if (rv !== 16'h0001) begin nfail++; $display("FAIL decode_below got %h want %h", rv, 16'h0001); end
    cycle(4'h3, 0, 1, 12);
    nvec++; if (rv !== 16'h0001) begin nfail++; $display("FAIL decode_above got %h want %h", rv, 16'h0001); end
    cycle(4'h3, 0, 1, 9);
    nvec++; if (rv !== 16'h0002) begin nfail++; $display("FAIL decode_kept_press got %h want %h", rv, 16'h0002); end
    cycle(4'h3, 0, 1, 8);
    nvec++; if (rv !== 16'h0003) begin nfail++; $display("FAIL decode_state got %h want %h", rv, 16'h0003); end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic v;
    b = buttons;
    v = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 15) == 0) v = ~v;
      if (n == 1500) begin
        #2 reset = 1;
        m_clear();
        repeat (2) cycle(b, v, 1, 8);
        reset = 0;
      end
      cycle(b, v, 1'($urandom_range(0, 1)), 7'($urandom_range(6, 13)));
      nvec++;
      if (rv !== m_out) begin
        nfail++;
        $display("FAIL random_read n=%0d got %h want %h", n, rv, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_clear_on_read();
    test_simultaneous();
    test_vblank();
    test_decode();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/button_controller.md
# button_controller

Register-bus responder that services processor reads of the game's buttons and vertical-blank status. It synchronizes and debounces the four button inputs and latches press, release and vblank-start events until software reads them. It sits on the ulisp register bus beside the display controller: the display controller consumes register writes, and this block answers register reads.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles (10 ms at 25 MHz) required to accept a button change; minimum 2.
- BASE_INDEX, 0, first register index decoded. The block occupies BASE_INDEX..BASE_INDEX+3.

Ports:
- clk  input  1  system clock (25 MHz game clock).
- reset  input  1  asynchronous, active-high reset.
- buttons_i  input  4  raw buttons, active-high, asynchronous to clk.
- in_vblank_i  input  1  vblank level from display_controller, already synchronous to clk.
- register_index_i  input  7  register index from the processor.
- register_read_i  input  1  read strobe, one cycle per read.
- register_read_value_o  output  16  read data.

## Operation

- Synchronizer: each button bit passes through two flops (sync0, sync1) before any other logic.
- Debounce, per button:
  - Keep a counter sized to hold DEBOUNCE_CYCLES-1 and a debounced state bit.
  - If sync1 equals the state, the counter clears.
  - Otherwise the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while sync1 still differs, the state takes sync1 and the counter clears.
  - That state change asserts an internal event: a press event for 0->1, a release event for 1->0.
- Event latches:
  - press_lat[3:0] and release_lat[3:0] set on their events.
  - vbs_lat sets on the cycle in_vblank_i is 1 while the registered prev_vblank is 0.
- Register map, relative to BASE_INDEX:
  - +0: {12'd0, state}.
  - +1: {12'd0, press_lat | press_evt}; clears press_lat.
  - +2: {12'd0, release_lat | release_evt}; clears release_lat.
  - +3: {14'd0, vbs_lat | vbs_evt, in_vblank_i}; clears vbs_lat.
- Simultaneous event and clearing read: the event is returned in that read's data and is not left latched. No event is ever lost or reported twice.
- Index outside the four decoded registers, or register_read_i low: register_read_value_o holds its previous value and no latch clears.
- Reset, including mid-debounce or with pending events: sync flops, counters, state, all latches, prev_vblank and register_read_value_o go to 0. Pending events are discarded, and buttons held through reset are reported as presses after debounce.

## Timing

- Read latency is one cycle. register_read_value_o updates on the rising edge of clk at which register_read_i=1 and the index decodes, and is valid from then until the next decoded read.
- Clear-on-read latches clear on that same edge.
- Button acceptance: a level change that arrives at buttons_i before edge N and stays stable appears in sync1 after edge N+1. The state changes at edge N+1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES cycles in sync1 never changes the state.
- vbs_lat sets on the edge after the first cycle in which in_vblank_i is high.
- No combinational path exists from any input to register_read_value_o.

## Test plan

- Reset: assert reset asynchronously mid-cycle with buttons_i=4'hF -> register_read_value_o=0 immediately. Release reset, wait 2+DEBOUNCE_CYCLES -> reading +0 returns 16'h000F and reading +1 returns 16'h000F.
- Debounce (DEBOUNCE_CYCLES=4): pulse buttons_i[1] high for 3 cycles -> reading +0 returns 0 and reading +1 returns 0. Hold it 4 or more cycles -> state bit 1 sets exactly at edge N+5, and reading +1 returns 16'h0002.
- Clear-on-read: press and release button 2, then read +2 twice -> first read 16'h0004, second read 16'h0000. Reading +0 afterwards returns 16'h0000.
- Simultaneous event and read: time the read of +1 onto the exact edge where button 0's press is accepted -> read returns 16'h0001, and the next read of +1 returns 0.
- Vblank: drive in_vblank_i 0->1 for 10 cycles and read +3 during vblank -> 16'h0003. Read +3 again while still in vblank -> 16'h0001. Read +3 after vblank ends -> 16'h0000.
- Decode (BASE_INDEX=8): read index 7 and index 12 -> output unchanged and no latches cleared. Read index 8 -> returns the button state.
